// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared types, constants and result fix-up for the RV32M mul/div sequencer
package kamus_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_OVF_Q  = 32'h8000_0000;

  // Applies the sign fix-up to a magnitude result and picks the architectural word.
  function automatic logic [31:0] md_fixup(input md_op_e op, input logic [63:0] acc,
                                           input logic [31:0] quot, input logic sa,
                                           input logic sb);
    logic [63:0] prod;
    logic [31:0] res;
    prod = (sa ^ sb) ? (64'd0 - acc) : acc;
    case (op)
      MUL:                 res = prod[31:0];
      MULH, MULHSU, MULHU: res = prod[63:32];
      DIV, DIVU:           res = (sa ^ sb) ? (32'd0 - quot) : quot;
      default:             res = sa ? (32'd0 - acc[31:0]) : acc[31:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/kamus_md_step.sv
// rtl/kamus_md_step.sv - one combinational radix-2 shift-add / restoring shift-subtract step
module kamus_md_step
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              bit_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_o
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Bits are consumed MSB first, so multiply accumulates by doubling before adding.
  always_comb begin
    acc_o = '0;
    q_o   = 1'b0;
    trial = {acc_i[XLEN-1:0], bit_i};
    diff  = trial - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = {{XLEN{1'b0}}, diff[XLEN-1:0]};
        q_o   = 1'b1;
      end else begin
        acc_o = {{XLEN{1'b0}}, trial[XLEN-1:0]};
      end
    end else begin
      acc_o = (acc_i << 1) + (bit_i ? {{XLEN{1'b0}}, opnd_i} : {(2*XLEN){1'b0}});
    end
  end

endmodule

// File: rtl/kamus_muldiv_seq.sv
// rtl/kamus_muldiv_seq.sv - RV32M multi-cycle mul/div sequencer; KAMUS_MUL_1CYC_EN selects single-cycle multiply
module kamus_muldiv_seq
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   shreg_q, shreg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              in_div, sgn_a, sgn_b, div0, ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] step_acc;
  logic              step_q;
  logic [XLEN-1:0]   quot_next;

  assign op_in  = md_op_e'(op_i);
  assign in_div = op_i[2];
  assign sgn_a  = rs1_data_i[XLEN-1] &
                  ((op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM));
  assign sgn_b  = rs2_data_i[XLEN-1] & ((op_in == MULH) || (op_in == DIV) || (op_in == REM));
  assign mag_a  = sgn_a ? (XLEN'(0) - rs1_data_i) : rs1_data_i;
  assign mag_b  = sgn_b ? (XLEN'(0) - rs2_data_i) : rs2_data_i;
  assign div0   = in_div && (rs2_data_i == '0);
  assign ovf    = ((op_in == DIV) || (op_in == REM)) &&
                  (rs1_data_i == MD_OVF_Q) && (rs2_data_i == MD_DIV0_Q);

`ifdef KAMUS_MUL_1CYC_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  kamus_md_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .bit_i    (shreg_q[XLEN-1]),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  // The operand shift register doubles as the quotient register while dividing.
  assign quot_next = {shreg_q[XLEN-2:0], step_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    opnd_d   = opnd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req_i && !kill_i) begin
          op_d    = op_in;
          sa_d    = sgn_a;
          sb_d    = sgn_b;
          shreg_d = mag_a;
          opnd_d  = mag_b;
          acc_d   = '0;
          cnt_d   = 5'd31;
          if (div0) begin
            result_d = op_i[1] ? rs1_data_i : MD_DIV0_Q;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = op_i[1] ? '0 : MD_OVF_Q;
            state_d  = DONE;
`ifdef KAMUS_MUL_1CYC_EN
          end else if (!in_div) begin
            result_d = md_fixup(op_in, fast_prod, '0, sgn_a, sgn_b);
            state_d  = DONE;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = step_acc;
        shreg_d = quot_next;
        if (cnt_q == 5'd0) begin
          state_d  = DONE;
          result_d = md_fixup(op_q, step_acc, quot_next, sa_q, sb_q);
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      shreg_q  <= '0;
      opnd_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      opnd_q   <= opnd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == DONE);
  assign stall_o  = ((state_q == IDLE) && req_i) || (state_q == CALC);
  assign result_o = result_q;

endmodule

// File: tb/tb_kamus_muldiv_seq.sv
// tb/tb_kamus_muldiv_seq.sv - directed self-checking bench for kamus_muldiv_seq
module tb_kamus_muldiv_seq;

`ifdef KAMUS_MUL_1CYC_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  localparam logic [2:0] O_MUL = 3'd0, O_MULH = 3'd1, O_MULHSU = 3'd2, O_MULHU = 3'd3;
  localparam logic [2:0] O_DIV = 3'd4, O_DIVU = 3'd5, O_REM = 3'd6, O_REMU = 3'd7;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o, stall_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  kamus_muldiv_seq #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .kill_i     (kill_i),
    .ready_o    (ready_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk_i);
    chk({name, " ready"}, {31'd0, ready_o}, 32'd1);
    req_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b;
    #1 chk({name, " stall_accept"}, {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    req_i = 1'b0; rs1_data_i = $urandom; rs2_data_i = $urandom;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    chk({name, " latency"}, cyc, lat);
    chk({name, " result"}, result_o, exp);
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic [31:0] last_exp;

    vecs[0]  = '{O_DIVU,   32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{O_REMU,   32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{O_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{O_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{O_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MUL_LAT};
    vecs[5]  = '{O_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT};
    vecs[6]  = '{O_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  MUL_LAT};
    vecs[7]  = '{O_MUL,    32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  MUL_LAT};
    vecs[8]  = '{O_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{O_REM,    32'd5,          32'd0,          32'd5,          1};
    vecs[10] = '{O_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{O_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[12] = '{O_DIV,    32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33};
    vecs[13] = '{O_REM,    32'd100,        32'hFFFF_FFF9,  32'd2,          33};
    vecs[14] = '{O_MUL,    32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB,  MUL_LAT};
    vecs[15] = '{O_REMU,   32'hFFFF_FFFF,  32'h10,         32'hF,          33};
    vecs[16] = '{O_DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[17] = '{O_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF,  MUL_LAT};

    repeat (2) @(negedge clk_i);
    chk("reset ready", {31'd0, ready_o}, 32'd1);
    chk("reset done", {31'd0, done_o}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    last_exp = vecs[17].exp;

    // Kill in CALC cycle 10.
    @(negedge clk_i);
    req_i = 1'b1; op_i = O_DIV; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
    @(negedge clk_i);
    req_i = 1'b0;
    seen = done_o;
    repeat (9) begin
      @(negedge clk_i);
      seen = seen | done_o;
    end
    chk("kill stall_calc", {31'd0, stall_o}, 32'd1);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    chk("kill ready", {31'd0, ready_o}, 32'd1);
    chk("kill result_held", result_o, last_exp);
    repeat (40) begin
      @(negedge clk_i);
      seen = seen | done_o;
    end
    chk("kill no_done", {31'd0, seen}, 32'd0);
    run_op("after_kill", O_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Reset in the middle of CALC.
    @(negedge clk_i);
    req_i = 1'b1; op_i = O_DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst ready", {31'd0, ready_o}, 32'd1);
    chk("midrst result", result_o, 32'd0);
    chk("midrst stall", {31'd0, stall_o}, 32'd0);
    chk("midrst done", {31'd0, done_o}, 32'd0);
    rst_ni = 1'b1;

    // Request together with kill in IDLE must be dropped.
    @(negedge clk_i);
    req_i = 1'b1; kill_i = 1'b1; op_i = O_DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
    @(negedge clk_i);
    req_i = 1'b0; kill_i = 1'b0;
    chk("reqkill ready", {31'd0, ready_o}, 32'd1);
    chk("reqkill done", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    chk("reqkill ready2", {31'd0, ready_o}, 32'd1);

    // Request held through CALC with a different op.
    @(negedge clk_i);
    req_i = 1'b1; op_i = O_DIVU; rs1_data_i = 32'd100; rs2_data_i = 32'd7;
    @(negedge clk_i);
    op_i = O_MUL; rs1_data_i = 32'd5; rs2_data_i = 32'd6;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("held first_latency", cyc, 33);
    chk("held first_result", result_o, 32'd14);
    chk("held done_not_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    chk("held idle_ready", {31'd0, ready_o}, 32'd1);
    chk("held idle_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("held second_latency", cyc, MUL_LAT);
    chk("held second_result", result_o, 32'd30);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
